// File: rtl/nor_cmd_seq.sv
// nor_cmd_seq: command sequencer for a parallel NOR flash (CUI-style commands).
// Runs unlock, read ID, block erase with status polling, read status and
// read array as sequences of strobe-timed write/read bus cycles.
// Build option: define NOR_ERASE_TIMEOUT_EN to bound erase polling to POLL_MAX
// status reads; without it, polling continues until the device reports ready.
module nor_cmd_seq #(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 16,
  parameter int unsigned T_RST    = 8,
  parameter int unsigned T_WP     = 2,
  parameter int unsigned T_WH     = 1,
  parameter int unsigned T_ACC    = 4,
  parameter int unsigned POLL_MAX = 2**24
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    OP,
  input  logic [AW-1:0] ADDR_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [DW-1:0] RDATA,
  output logic          CE,
  output logic          WE,
  output logic          OE,
  output logic [AW-1:0] ADDR,
  inout  wire  [DW-1:0] DATA
);

  typedef enum logic [2:0] {
    IDLE, PWR_WAIT, WR_LO, WR_HI, RD_ACC, RD_CAP, POLL_CHK, FIN
  } state_t;

  // Kind of bus action at a given step of an operation's command script.
  typedef enum logic [1:0] {ACT_WR, ACT_RD, ACT_POLL, ACT_END} act_t;

  localparam int unsigned CW      = 16;
  localparam int unsigned LIM_RST = (T_RST > 0) ? T_RST - 1 : 0;
  localparam int unsigned LIM_WP  = (T_WP  > 0) ? T_WP  - 1 : 0;
  localparam int unsigned LIM_WH  = (T_WH  > 0) ? T_WH  - 1 : 0;
  // RD_CAP is the last strobed access cycle, so RD_ACC covers the first T_ACC-1.
  localparam int unsigned LIM_ACC = (T_ACC > 1) ? T_ACC - 2 : 0;

  // Command script: which action each step of each opcode performs.
  function automatic act_t f_kind(input logic [2:0] op, input logic [2:0] step);
    act_t k;
    k = ACT_END;
    case (op)
      3'd0: begin
        if (step < 3'd2) k = ACT_WR;
      end
      3'd1, 3'd3, 3'd4: begin
        if (step == 3'd0)      k = ACT_WR;
        else if (step == 3'd1) k = ACT_RD;
      end
      3'd2: begin
        case (step)
          3'd0, 3'd1, 3'd3: k = ACT_WR;
          3'd2:             k = ACT_POLL;
          default:          k = ACT_END;
        endcase
      end
      default: k = ACT_END;
    endcase
    return k;
  endfunction

  // Command byte written at a given write step.
  function automatic logic [7:0] f_cmd(input logic [2:0] op, input logic [2:0] step);
    logic [7:0] c;
    case (op)
      3'd0:    c = (step == 3'd0) ? 8'h60 : 8'hD0;
      3'd1:    c = 8'h90;
      3'd2:    c = (step == 3'd0) ? 8'h20 : ((step == 3'd1) ? 8'hD0 : 8'hFF);
      3'd3:    c = 8'h70;
      3'd4:    c = 8'hFF;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Bus state that starts a given action.
  function automatic state_t f_enter(input act_t k);
    state_t s;
    case (k)
      ACT_WR:           s = WR_LO;
      ACT_RD, ACT_POLL: s = RD_ACC;
      default:          s = FIN;
    endcase
    return s;
  endfunction

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [2:0]    r_step;
  logic [2:0]    w_step_nxt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] w_wdata;
  logic          r_err;
  logic          w_accept;
  logic          w_poll_ok;
  logic          w_poll_abort;
  logic          w_drive;
  act_t          w_kind_cur;
  act_t          w_kind_nxt;

`ifdef NOR_ERASE_TIMEOUT_EN
  localparam int unsigned PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] r_polls;

  // Count status reads of the current erase for the poll timeout.
  always_ff @(posedge CLK) begin
    if (RESET || w_accept)
      r_polls <= '0;
    else if (r_state == RD_CAP && w_kind_cur == ACT_POLL)
      r_polls <= r_polls + PCW'(1);
  end
`endif

  // Next-state, script step advance and accept/poll decisions.
  always_comb begin
    w_next       = r_state;
    w_step_nxt   = r_step;
    w_accept     = 1'b0;
    w_poll_ok    = 1'b0;
    w_poll_abort = 1'b0;
    w_kind_cur   = f_kind(r_op, r_step);
    w_kind_nxt   = f_kind(r_op, r_step + 3'd1);
    case (r_state)
      PWR_WAIT: begin
        if (r_cnt == CW'(LIM_RST)) w_next = IDLE;
      end
      IDLE, FIN: begin
        w_next = IDLE;
        if (START) begin
          w_accept   = 1'b1;
          w_step_nxt = 3'd0;
          w_next     = f_enter(f_kind(OP, 3'd0));
        end
      end
      WR_LO: begin
        if (r_cnt == CW'(LIM_WP)) w_next = WR_HI;
      end
      WR_HI: begin
        if (r_cnt == CW'(LIM_WH)) begin
          w_step_nxt = r_step + 3'd1;
          w_next     = f_enter(w_kind_nxt);
        end
      end
      RD_ACC: begin
        if (r_cnt == CW'(LIM_ACC)) w_next = RD_CAP;
      end
      RD_CAP: begin
        if (w_kind_cur == ACT_POLL) begin
          w_next = POLL_CHK;
        end else begin
          w_step_nxt = r_step + 3'd1;
          w_next     = f_enter(w_kind_nxt);
        end
      end
      POLL_CHK: begin
        if (r_rdata[7]) begin
          w_poll_ok  = 1'b1;
          w_step_nxt = r_step + 3'd1;
          w_next     = f_enter(w_kind_nxt);
`ifdef NOR_ERASE_TIMEOUT_EN
        end else if (r_polls >= PCW'(POLL_MAX)) begin
          w_poll_abort = 1'b1;
          w_step_nxt   = r_step + 3'd1;
          w_next       = f_enter(w_kind_nxt);
`endif
        end else begin
          w_next = RD_ACC;
        end
      end
      default: w_next = PWR_WAIT;
    endcase
  end

  // State register; reset restarts the power-up wait.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= PWR_WAIT;
    else       r_state <= w_next;
  end

  // Phase timer: restarts on every state change.
  always_ff @(posedge CLK) begin
    if (RESET || (r_state != w_next)) r_cnt <= '0;
    else                              r_cnt <= r_cnt + CW'(1);
  end

  // Operation context, read capture and error flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op    <= '0;
      r_step  <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      if (w_accept) begin
        r_op   <= OP;
        r_addr <= ADDR_IN;
        r_err  <= (f_kind(OP, 3'd0) == ACT_END);
      end
      if (r_state == RD_CAP) r_rdata <= DATA;
      if (w_poll_ok)    r_err <= r_rdata[5] | r_rdata[4] | r_rdata[3] | r_rdata[1];
      if (w_poll_abort) r_err <= 1'b1;
    end
  end

  // Write data: command byte zero-extended to the bus width.
  always_comb begin
    w_wdata      = '0;
    w_wdata[7:0] = f_cmd(r_op, r_step);
  end

  assign w_drive = (r_state == WR_LO) || (r_state == WR_HI);
  assign DATA    = w_drive ? w_wdata : 'z;

  assign CE    = !((r_state == WR_LO) || (r_state == RD_ACC) || (r_state == RD_CAP));
  assign WE    = !(r_state == WR_LO);
  assign OE    = !((r_state == RD_ACC) || (r_state == RD_CAP));
  assign ADDR  = (r_op == 3'd1 && r_step == 3'd1) ? (r_addr + AW'(2)) : r_addr;
  assign BUSY  = !((r_state == IDLE) || (r_state == FIN));
  assign DONE  = (r_state == FIN);
  assign ERR   = r_err;
  assign RDATA = r_rdata;

endmodule

// File: tb/tb_nor_cmd_seq.sv
// Testbench for nor_cmd_seq: flash bus model plus scoreboard of expected bus
// cycles and completions, with directed and randomized operations.
`timescale 1ns/1ps
module tb_nor_cmd_seq;

  localparam int unsigned AW = 24, DW = 16;
  localparam int unsigned T_RST = 8, T_WP = 2, T_WH = 1, T_ACC = 4, POLL_MAX = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [2:0]    OP = '0;
  logic [AW-1:0] ADDR_IN = '0;
  logic          BUSY, DONE, ERR, CE, WE, OE;
  logic [DW-1:0] RDATA;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] DATA;

  nor_cmd_seq #(.AW(AW), .DW(DW), .T_RST(T_RST), .T_WP(T_WP), .T_WH(T_WH),
                .T_ACC(T_ACC), .POLL_MAX(POLL_MAX)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .ADDR_IN(ADDR_IN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .CE(CE), .WE(WE), .OE(OE), .ADDR(ADDR), .DATA(DATA));

  always #5 CLK = ~CLK;

  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } bus_ev_t;
  typedef struct packed { logic [DW-1:0] rdata; logic err; } done_ev_t;

  bus_ev_t       exp_bus[$];
  done_ev_t      exp_done[$];
  logic [DW-1:0] rd_mem [0:63];
  int unsigned   wr_ptr = 0, rd_ptr = 0;
  logic [DW-1:0] mdl_rdata = '0;
  int            n_vec = 0, n_bad = 0, n_done = 0;
  logic          strobe_bad = 1'b0;

  // Flash model: returns the next scripted word while CE and OE are low.
  assign DATA = (!CE && !OE && WE) ? rd_mem[rd_ptr % 64] : 'z;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_wr(input logic [AW-1:0] a, input logic [7:0] c);
    bus_ev_t e;
    e.wr = 1'b1; e.addr = a; e.data = DW'(c);
    exp_bus.push_back(e);
  endfunction

  function automatic void push_rd(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bus_ev_t e;
    e.wr = 1'b0; e.addr = a; e.data = v;
    exp_bus.push_back(e);
    rd_mem[wr_ptr % 64] = v;
    wr_ptr++;
  endfunction

  // Monitor: turns strobe activity into bus events and checks them and DONE.
  initial begin : monitor
    int unsigned   we_len, oe_len;
    logic [AW-1:0] w_a, r_a;
    logic [DW-1:0] w_d;
    bus_ev_t       e;
    done_ev_t      d;
    we_len = 0; oe_len = 0; w_a = '0; r_a = '0; w_d = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        we_len = 0; oe_len = 0; rd_ptr = wr_ptr; strobe_bad = 1'b0;
      end else begin
        if ((!WE && !OE) || ((!WE || !OE) && CE)) strobe_bad = 1'b1;
        if (!WE) begin
          if (we_len == 0) begin w_a = ADDR; w_d = DATA; end
          we_len++;
        end else if (we_len != 0) begin
          chk("wr_low_cycles", we_len, T_WP);
          chk("wr_expected", exp_bus.size() != 0, 1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            chk("wr_kind", e.wr, 1);
            chk("wr_addr", w_a, e.addr);
            chk("wr_data", w_d, e.data);
          end
          we_len = 0;
        end
        if (!OE) begin
          if (oe_len == 0) r_a = ADDR;
          oe_len++;
        end else if (oe_len != 0) begin
          chk("rd_low_cycles", oe_len, T_ACC);
          chk("rd_expected", exp_bus.size() != 0, 1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            chk("rd_kind", e.wr, 0);
            chk("rd_addr", r_a, e.addr);
          end
          rd_ptr++;
          oe_len = 0;
        end
        if (DONE) begin
          chk("done_expected", exp_done.size() != 0, 1);
          if (exp_done.size() != 0) begin
            d = exp_done.pop_front();
            chk("rdata", RDATA, d.rdata);
            chk("err", ERR, d.err);
          end
          chk("bus_events_left", exp_bus.size(), 0);
          chk("busy_at_done", BUSY, 0);
          chk("strobe_rules", strobe_bad, 0);
          strobe_bad = 1'b0;
          n_done++;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 3000) begin @(negedge CLK); n++; end
    if (BUSY) chk("idle_wait", BUSY, 0);
  endtask

  task automatic pwr_wait_check();
    int n;
    n = 0;
    while (BUSY && n < 100) begin n++; @(negedge CLK); end
    chk("pwr_wait_cycles", n, T_RST);
  endtask

  // Reference model: expected bus cycles and result of one operation, then drive it.
  task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a, input int n_busy,
                        input logic [DW-1:0] rv, input bit stuck, input bit poke);
    logic [DW-1:0] bv;
    done_ev_t      de;
    int            d0, n;
    de.err = 1'b0;
    case (op)
      3'd0: begin push_wr(a, 8'h60); push_wr(a, 8'hD0); end
      3'd1: begin push_wr(a, 8'h90); push_rd(a + AW'(2), rv); mdl_rdata = rv; end
      3'd2: begin
        push_wr(a, 8'h20); push_wr(a, 8'hD0);
        if (stuck) begin
          for (int i = 0; i < int'(POLL_MAX); i++) push_rd(a, '0);
          mdl_rdata = '0;
          de.err = 1'b1;
        end else begin
          for (int i = 0; i < n_busy; i++) begin
            bv = DW'($urandom); bv[7] = 1'b0;
            push_rd(a, bv);
          end
          push_rd(a, rv);
          mdl_rdata = rv;
          de.err = (rv & DW'(16'h003A)) != '0;
        end
        push_wr(a, 8'hFF);
      end
      3'd3: begin push_wr(a, 8'h70); push_rd(a, rv); mdl_rdata = rv; end
      3'd4: begin push_wr(a, 8'hFF); push_rd(a, rv); mdl_rdata = rv; end
      default: de.err = 1'b1;
    endcase
    de.rdata = mdl_rdata;
    exp_done.push_back(de);
    wait_idle();
    d0 = n_done;
    @(negedge CLK);
    START = 1'b1; OP = op; ADDR_IN = a;
    @(negedge CLK);
    START = 1'b0; OP = 3'($urandom); ADDR_IN = AW'($urandom);
    if (op <= 3'd4) chk("busy_after_accept", BUSY, 1);
    else            chk("illegal_done_next", DONE, 1);
    if (poke && op <= 3'd4) begin
      @(negedge CLK); @(negedge CLK);
      START = 1'b1; OP = 3'($urandom_range(0, 4)); ADDR_IN = AW'($urandom);
      @(negedge CLK);
      START = 1'b0;
    end
    n = 0;
    while (n_done == d0 && n < 3000) begin @(negedge CLK); n++; end
    chk("op_completed", n_done != d0, 1);
  endtask

  // Reset landing in the first write of an erase abandons it.
  task automatic reset_mid_erase();
    int n;
    wait_idle();
    @(negedge CLK);
    START = 1'b1; OP = 3'd2; ADDR_IN = 24'h123456;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (WE && n < 50) begin @(negedge CLK); n++; end
    chk("reached_wr_lo", WE, 0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_ce", CE, 1); chk("rst_we", WE, 1); chk("rst_oe", OE, 1);
    chk("rst_busy", BUSY, 1); chk("rst_done", DONE, 0); chk("rst_addr", ADDR, 0);
    exp_bus.delete(); exp_done.delete(); mdl_rdata = '0;
    @(negedge CLK);
    chk("rst_rdata", RDATA, 0); chk("rst_err", ERR, 0);
    RESET = 1'b0;
    pwr_wait_check();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] rv;
    int            nb;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_ce", CE, 1); chk("reset_we", WE, 1); chk("reset_oe", OE, 1);
    chk("reset_addr", ADDR, 0); chk("reset_rdata", RDATA, 0);
    chk("reset_done", DONE, 0); chk("reset_err", ERR, 0); chk("reset_busy", BUSY, 1);
    RESET = 1'b0;
    pwr_wait_check();

    run_op(3'd0, 24'h3F0000, 0, '0, 1'b0, 1'b0);
    run_op(3'd1, 24'h3F0000, 0, 16'h0001, 1'b0, 1'b0);
`ifndef NOR_ERASE_TIMEOUT_EN
    run_op(3'd2, 24'h3F0000, 10, 16'h0080, 1'b0, 1'b0);
`else
    run_op(3'd2, 24'h3F0000, 3, 16'h0080, 1'b0, 1'b0);
    run_op(3'd2, 24'h200000, 0, '0, 1'b1, 1'b0);
`endif
    run_op(3'd2, 24'h010000, 1, 16'h00A0, 1'b0, 1'b0);
    run_op(3'd1, 24'hFFFFFE, 0, 16'h89AB, 1'b0, 1'b0);
    run_op(3'd1, 24'hFFFFFF, 0, 16'h4321, 1'b0, 1'b1);
    run_op(3'd3, 24'h000100, 0, 16'h0080, 1'b0, 1'b0);
    run_op(3'd4, 24'h000ABC, 0, 16'hBEEF, 1'b0, 1'b0);
    run_op(3'd7, 24'h000000, 0, '0, 1'b0, 1'b0);
    run_op(3'd5, 24'h111111, 0, '0, 1'b0, 1'b0);
    reset_mid_erase();
    run_op(3'd7, 24'h000000, 0, '0, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      a  = AW'($urandom);
      rv = DW'($urandom);
      if (op == 3'd2) rv[7] = 1'b1;
`ifdef NOR_ERASE_TIMEOUT_EN
      nb = $urandom_range(0, 2);
`else
      nb = $urandom_range(0, 5);
`endif
      run_op(op, a, nb, rv, 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
